dc_fill_sequencer: RTL and testbench
====================================

DC_FILL_SEQUENCER -- requirements
Module: dc_fill_sequencer

Interface
REQ-001 Parameter Width, default 36, bank entry width: 32 data bits plus a 4-bit write mask in [35:32].
REQ-002 Parameter Size, default 512, entries per databank; position width is log2(Size) = 9.
REQ-003 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1, synchronous, active-low reset (0 = reset).
REQ-005 Port fill_valid, input, 1, line-fill request from L2 is valid.
REQ-006 Port fill_retry, output, 1, sequencer cannot accept a fill this cycle.
REQ-007 Port fill_addr, input, 29, logical line address; set index = fill_addr[10:6].
REQ-008 Port fill_way, input, 2, destination way.
REQ-009 Port fill_data, input, 512, 16 words; word w = fill_data[32w+31:32w].
REQ-010 Port fill_done, output, 1, one-cycle pulse when all 16 words have been accepted by the banks.
REQ-011 Port bank_req_valid, output, 4, per-bank write request valid.
REQ-012 Port bank_req_retry, input, 4, per-bank back-pressure.
REQ-013 Port bank_write, output, 1, constant 1 while any bank_req_valid bit is set; 0 otherwise.
REQ-014 Port bank_req_pos, output, 9, shared entry position for all four banks.
REQ-015 Port bank_req_data, output, 144, bank b data in [36b+35:36b].

Function
REQ-016 Word mapping: word w goes to bank w[1:0], row w[3:2].
REQ-017 bank_req_pos SHALL equal {set[4:0], way[1:0], row[1:0]}, with set and way taken from the latched request.
REQ-018 Bank b data SHALL be {4'hF, word[row*4+b]}.
REQ-019 FSM states: IDLE, ISSUE, DONE.
REQ-020 IDLE: fill_retry=0; fill_valid=1 latches addr, way and data; row counter cleared to 0; pending mask set to 4'hF; next state ISSUE.
REQ-021 ISSUE: fill_retry=1; bank_req_valid equals the pending mask.
REQ-022 ISSUE: a bank b with bank_req_valid[b]=1 and bank_req_retry[b]=0 is accepted; its pending bit clears next cycle.
REQ-023 Row advance: when all still-pending banks are accepted in a cycle, row increments and the pending mask reloads to 4'hF next cycle.
REQ-024 Row wrap: if row==3 when the row advance occurs, the next state is DONE and the row does not wrap.
REQ-025 DONE: fill_done=1 and fill_retry=1 for exactly one cycle; bank_req_valid=0; next state IDLE.
REQ-026 Banks accepted earlier in the current row SHALL NOT be re-issued; pos and data stay stable while any bit is pending.
REQ-027 Minimum latency with no retries: fill accepted at cycle N; rows 0..3 issued at N+1..N+4; fill_done at N+5; next fill accepted no earlier than N+6.
REQ-028 In IDLE, fill_valid=0 leaves all state unchanged.
REQ-029 fill_valid in ISSUE or DONE is ignored (fill_retry=1).

Reset
REQ-030 On reset=0 at a clock edge: state goes to IDLE, row=0, pending=0; reset takes priority over all other inputs.
REQ-031 Outputs during and immediately after reset: bank_req_valid=0, bank_write=0, fill_done=0, fill_retry=0, bank_req_pos=0, bank_req_data=0.
REQ-032 Reset mid-ISSUE aborts the fill: no further bank requests and no fill_done.

Structure
REQ-033 Shared DC package holds SET_INDEX_BITS=5, WAY_BITS=2, ROW_BITS=2, NUM_BANKS=4, the FSM state enum, and the position-composition function.
REQ-034 One sub-module, dc_fill_latch, is natural: it is the 512-bit request holding register with a word-select output.

Verification
REQ-035 No retry: fill_addr=29'h0000_0140 (set 5), way=2, data word w = 32'hA000_0000+w -> row r at cycles N+1+r, pos = 5*16+2*4+r = 88+r, bank b data = {4'hF, 32'hA000_0000+4r+b}, fill_done at N+5.
REQ-036 bank_req_retry=4'b0100 for 3 cycles on row 0 -> banks 0, 1 and 3 are accepted in the first cycle and then drop valid; bank 2 is held 3 more cycles; row 1 starts on the cycle after bank 2 is accepted; fill_done at N+8.
REQ-037 fill_valid held high continuously -> fills accepted only in IDLE, with a 6-cycle spacing; fill_retry=1 in ISSUE and DONE.
REQ-038 reset=0 during row 2 -> the next cycle has bank_req_valid=0 and the state is IDLE; no fill_done pulse ever appears for the aborted fill.
REQ-039 Boundary values: set=31, way=3 -> pos 508..511, no overflow; set=0, way=0 -> pos 0..3.

Source files
------------

// File: rtl/dc_fill_sequencer_pkg.sv
// Shared data-cache fill definitions: geometry of the line/bank arrangement,
// the fill FSM state encoding and the bank entry position helper.
package dc_fill_sequencer_pkg;

  localparam int SET_INDEX_BITS = 5;
  localparam int WAY_BITS       = 2;
  localparam int ROW_BITS       = 2;
  localparam int NUM_BANKS      = 4;

  localparam int POS_BITS      = SET_INDEX_BITS + WAY_BITS + ROW_BITS;
  localparam int SET_LSB       = 6;
  localparam int WORD_BITS     = 32;
  localparam int ROW_DATA_BITS = NUM_BANKS * WORD_BITS;
  localparam int LINE_BITS     = ROW_DATA_BITS << ROW_BITS;

  localparam logic [3:0]           WRITE_MASK_ALL = 4'hF;
  localparam logic [NUM_BANKS-1:0] ALL_BANKS      = '1;
  localparam logic [ROW_BITS-1:0]  ROW_LAST       = '1;

  typedef enum logic [1:0] {
    FILL_IDLE  = 2'd0,
    FILL_ISSUE = 2'd1,
    FILL_DONE  = 2'd2
  } fill_state_e;

  // Entry position shared by all banks: set selects a 16-entry block,
  // way a 4-entry group inside it, row the entry inside the group.
  function automatic logic [POS_BITS-1:0] compose_pos(
    input logic [SET_INDEX_BITS-1:0] set_idx,
    input logic [WAY_BITS-1:0]       way,
    input logic [ROW_BITS-1:0]       row
  );
    return {set_idx, way, row};
  endfunction

endpackage

// File: rtl/dc_fill_latch.sv
// Holds one 512-bit fill line for the duration of its issue phase and
// presents the four words of the selected row, bank 0 in the low word.
module dc_fill_latch
  import dc_fill_sequencer_pkg::*;
(
  input  logic                     clk,
  input  logic                     load,
  input  logic [LINE_BITS-1:0]     line_in,
  input  logic [ROW_BITS-1:0]      row_sel,
  output logic [ROW_DATA_BITS-1:0] row_words
);

  logic [LINE_BITS-1:0] line_q;

  // Capture the line only when a fill is accepted; contents are don't-care otherwise.
  always_ff @(posedge clk) begin
    if (load) begin
      line_q <= line_in;
    end
  end

  assign row_words = line_q[row_sel*ROW_DATA_BITS +: ROW_DATA_BITS];

endmodule

// File: rtl/dc_fill_sequencer.sv
// Sequences a 16-word L2 line fill into four data banks, one row of four
// words per cycle, re-issuing only the banks that pushed back.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | ready for a fill; fill_valid latches the request
//   ST_ISSUE   | driving the pending banks of the current row
//   ST_DONE    | one-cycle fill_done pulse, then back to idle
module dc_fill_sequencer
  import dc_fill_sequencer_pkg::*;
#(
  parameter int Width = 36,
  parameter int Size  = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fill_valid,
  output logic                     fill_retry,
  input  logic [28:0]              fill_addr,
  input  logic [1:0]               fill_way,
  input  logic [511:0]             fill_data,
  output logic                     fill_done,
  output logic [3:0]               bank_req_valid,
  input  logic [3:0]               bank_req_retry,
  output logic                     bank_write,
  output logic [$clog2(Size)-1:0]  bank_req_pos,
  output logic [4*Width-1:0]       bank_req_data
);

  localparam int PosW = $clog2(Size);

  localparam logic [1:0] ST_IDLE  = FILL_IDLE;
  localparam logic [1:0] ST_ISSUE = FILL_ISSUE;
  localparam logic [1:0] ST_DONE  = FILL_DONE;

  logic [1:0]                state;
  logic [ROW_BITS-1:0]       row;
  logic [NUM_BANKS-1:0]      pending;
  logic [NUM_BANKS-1:0]      remaining;
  logic [SET_INDEX_BITS-1:0] set_q;
  logic [WAY_BITS-1:0]       way_q;
  logic                      in_issue;
  logic                      load;
  logic [ROW_DATA_BITS-1:0]  row_words;
  logic                      unused_addr_bits;

  // Only the set index of the line address matters to the banks.
  assign unused_addr_bits = ^{fill_addr[28:SET_LSB+SET_INDEX_BITS], fill_addr[SET_LSB-1:0]};

  assign in_issue  = (state == ST_ISSUE);
  assign load      = reset && (state == ST_IDLE) && fill_valid;
  assign remaining = pending & bank_req_retry;

  dc_fill_latch u_latch (
    .clk       (clk),
    .load      (load),
    .line_in   (fill_data),
    .row_sel   (row),
    .row_words (row_words)
  );

  // Fill FSM, row counter and per-row pending-bank mask.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      row     <= '0;
      pending <= '0;
      set_q   <= '0;
      way_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fill_valid) begin
            set_q   <= fill_addr[SET_LSB +: SET_INDEX_BITS];
            way_q   <= fill_way;
            row     <= '0;
            pending <= ALL_BANKS;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (remaining == '0) begin
            if (row == ROW_LAST) begin
              pending <= '0;
              state   <= ST_DONE;
            end else begin
              row     <= row + 1'b1;
              pending <= ALL_BANKS;
            end
          end else begin
            pending <= remaining;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fill_retry     = (state != ST_IDLE);
  assign fill_done      = (state == ST_DONE);
  assign bank_req_valid = in_issue ? pending : '0;
  assign bank_write     = |bank_req_valid;
  assign bank_req_pos   = in_issue ? PosW'(compose_pos(set_q, way_q, row)) : '0;

  // Per-bank write entry: full write mask over the row's word; quiet outside issue.
  always_comb begin
    bank_req_data = '0;
    if (in_issue) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_req_data[b*Width +: Width] =
          Width'({WRITE_MASK_ALL, row_words[b*WORD_BITS +: WORD_BITS]});
      end
    end
  end

endmodule

// File: tb/tb_dc_fill_sequencer.sv
// Bench for dc_fill_sequencer: a word-level model (which of the 16 words are
// still owed to the banks) checked every cycle, plus directed scenarios with
// hand-computed expectations, then randomized fills, retries and resets.
module tb_dc_fill_sequencer;

  logic         clk;
  logic         reset;
  logic         fill_valid;
  logic         fill_retry;
  logic [28:0]  fill_addr;
  logic [1:0]   fill_way;
  logic [511:0] fill_data;
  logic         fill_done;
  logic [3:0]   bank_req_valid;
  logic [3:0]   bank_req_retry;
  logic         bank_write;
  logic [8:0]   bank_req_pos;
  logic [143:0] bank_req_data;

  dc_fill_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .fill_valid     (fill_valid),
    .fill_retry     (fill_retry),
    .fill_addr      (fill_addr),
    .fill_way       (fill_way),
    .fill_data      (fill_data),
    .fill_done      (fill_done),
    .bank_req_valid (bank_req_valid),
    .bank_req_retry (bank_req_retry),
    .bank_write     (bank_write),
    .bank_req_pos   (bank_req_pos),
    .bank_req_data  (bank_req_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_seen = 0;
  int acc_q[$];
  bit chk_en = 1'b0;

  // Model: a fill in flight owes 16 words; the banks always work on the
  // lowest row that still owes words. After the last word, one done cycle.
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  bit [15:0]   m_left = '0;
  logic [4:0]  m_set;
  logic [1:0]  m_way;
  logic [31:0] m_word [16];

  logic [28:0]  nxt_addr = '0;
  logic [1:0]   nxt_way = '0;
  logic [511:0] nxt_data = '0;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cur_row();
    for (int r = 0; r < 4; r++) begin
      if (m_left[4*r +: 4] != 4'h0) return r;
    end
    return 0;
  endfunction

  function automatic logic [3:0] exp_valid();
    int r;
    r = cur_row();
    return m_active ? m_left[4*r +: 4] : 4'h0;
  endfunction

  function automatic int exp_pos();
    return int'(m_set) * 16 + int'(m_way) * 4 + cur_row();
  endfunction

  function automatic logic [143:0] exp_data();
    logic [143:0] d;
    int r;
    r = cur_row();
    for (int b = 0; b < 4; b++) d[36*b +: 36] = {4'hF, m_word[4*r + b]};
    return d;
  endfunction

  function automatic logic [143:0] lit_row(input int r);
    logic [143:0] d;
    for (int b = 0; b < 4; b++) d[36*b +: 36] = {4'hF, 32'hA000_0000 + 32'(4*r + b)};
    return d;
  endfunction

  task automatic model_update();
    int r;
    logic [3:0] v;
    if (!reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_left   = '0;
    end else if (m_active) begin
      r = cur_row();
      v = m_left[4*r +: 4];
      m_left[4*r +: 4] = v & bank_req_retry;
      if (m_left == 16'h0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (fill_valid) begin
      m_active = 1'b1;
      m_left   = 16'hFFFF;
      m_set    = fill_addr[10:6];
      m_way    = fill_way;
      for (int w = 0; w < 16; w++) m_word[w] = fill_data[32*w +: 32];
    end
  endtask

  // Compare the DUT against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("retry", 144'(fill_retry), 144'(m_active || m_done));
      check("done", 144'(fill_done), 144'(m_done));
      check("valid", 144'(bank_req_valid), 144'(exp_valid()));
      check("write", 144'(bank_write), 144'(exp_valid() != 4'h0));
      if (exp_valid() != 4'h0) begin
        check("pos", 144'(bank_req_pos), 144'(exp_pos()));
        check("data", bank_req_data, exp_data());
      end
    end
  end

  task automatic step(input bit rst_n, input bit fv, input logic [3:0] rt);
    @(negedge clk);
    reset          = rst_n;
    fill_valid     = fv;
    bank_req_retry = rt;
    fill_addr      = nxt_addr;
    fill_way       = nxt_way;
    fill_data      = nxt_data;
    if (rst_n && fv && !fill_retry) acc_q.push_back(cyc);
    if (fill_done) done_seen++;
    @(posedge clk);
    model_update();
    cyc++;
  endtask

  task automatic rand_fill();
    nxt_addr = 29'($urandom);
    nxt_way  = 2'($urandom);
    for (int w = 0; w < 16; w++) nxt_data[32*w +: 32] = $urandom;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 144'(bank_req_valid), 144'(0));
    check({tag, "_write"}, 144'(bank_write), 144'(0));
    check({tag, "_done"}, 144'(fill_done), 144'(0));
    check({tag, "_retry"}, 144'(fill_retry), 144'(0));
    check({tag, "_pos"}, 144'(bank_req_pos), 144'(0));
    check({tag, "_data"}, bank_req_data, 144'(0));
  endtask

  initial begin
    int n;
    int done_at;
    int d0;
    logic [3:0] rt;

    reset          = 1'b0;
    fill_valid     = 1'b0;
    fill_addr      = '0;
    fill_way       = '0;
    fill_data      = '0;
    bank_req_retry = '0;

    // Reset wins over a simultaneous fill request.
    step(1'b0, 1'b1, 4'h0);
    chk_en = 1'b1;
    step(1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b1, 4'h0);
    #2 check_quiet("in_rst");
    step(1'b1, 1'b0, 4'h0);
    #2 check_quiet("post_rst");

    // Retry-free fill: set 5, way 2, words A0000000+w.
    nxt_addr = 29'h0000_0140;
    nxt_way  = 2'd2;
    for (int w = 0; w < 16; w++) nxt_data[32*w +: 32] = 32'hA000_0000 + 32'(w);
    step(1'b1, 1'b1, 4'h0);
    for (int r = 0; r < 4; r++) begin
      #2;
      check("nr_valid", 144'(bank_req_valid), 144'(4'hF));
      check("nr_pos", 144'(bank_req_pos), 144'(88 + r));
      check("nr_data", bank_req_data, lit_row(r));
      step(1'b1, 1'b0, 4'h0);
    end
    #2;
    check("nr_done_n5", 144'(fill_done), 144'(1));
    check("nr_done_valid", 144'(bank_req_valid), 144'(0));
    step(1'b1, 1'b0, 4'h0);
    #2;
    check("nr_idle_done", 144'(fill_done), 144'(0));
    check("nr_idle_retry", 144'(fill_retry), 144'(0));

    // Bank 2 held off for three cycles on row 0.
    rand_fill();
    step(1'b1, 1'b1, 4'h0);
    #2 check("bp_row0_all", 144'(bank_req_valid), 144'(4'hF));
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 4'b0100);
      #2 check("bp_bank2_only", 144'(bank_req_valid), 144'(4'b0100));
    end
    n = 4;
    done_at = -1;
    while (n < 20 && done_at < 0) begin
      step(1'b1, 1'b0, 4'h0);
      n++;
      #2;
      if (n == 5) begin
        check("bp_row1_valid", 144'(bank_req_valid), 144'(4'hF));
        check("bp_row1_pos", 144'(bank_req_pos[1:0]), 144'(1));
      end
      if (fill_done) done_at = n;
    end
    check("bp_done_cycle", 144'(done_at), 144'(8));
    step(1'b1, 1'b0, 4'h0);

    // fill_valid held high: accepted only from idle, every 6 cycles.
    acc_q.delete();
    for (int k = 0; k < 20; k++) begin
      rand_fill();
      step(1'b1, 1'b1, 4'h0);
    end
    check("hold_accepts", 144'(acc_q.size()), 144'(4));
    for (int i = 1; i < acc_q.size(); i++) begin
      check("hold_spacing", 144'(acc_q[i] - acc_q[i-1]), 144'(6));
    end
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 4'h0);

    // Reset during row 2 aborts the fill.
    rand_fill();
    step(1'b1, 1'b1, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    #2;
    check("abort_row2", 144'(bank_req_pos[1:0]), 144'(2));
    check("abort_row2_valid", 144'(bank_req_valid), 144'(4'hF));
    step(1'b0, 1'b0, 4'h0);
    #2;
    check("abort_valid", 144'(bank_req_valid), 144'(0));
    check("abort_idle", 144'(fill_retry), 144'(0));
    d0 = done_seen;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 4'h0);
    check("abort_no_done", 144'(done_seen), 144'(d0));

    // Position boundaries: top block (set 31, way 3) and bottom (set 0, way 0).
    nxt_addr = {18'h3FFFF, 5'd31, 6'h3F};
    nxt_way  = 2'd3;
    step(1'b1, 1'b1, 4'h0);
    for (int r = 0; r < 4; r++) begin
      #2 check("pos_top", 144'(bank_req_pos), 144'(508 + r));
      step(1'b1, 1'b0, 4'h0);
    end
    step(1'b1, 1'b0, 4'h0);
    nxt_addr = {18'h3FFFF, 5'd0, 6'h3F};
    nxt_way  = 2'd0;
    step(1'b1, 1'b1, 4'h0);
    for (int r = 0; r < 4; r++) begin
      #2 check("pos_bottom", 144'(bank_req_pos), 144'(r));
      step(1'b1, 1'b0, 4'h0);
    end
    step(1'b1, 1'b0, 4'h0);

    // Randomized traffic with back-pressure and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rand_fill();
      rt = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      step(($urandom_range(0, 199) != 0), 1'($urandom), rt);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
